// File: rtl/alu4_result_fifo_if.sv
// Handshake bundle between the ALU result FIFO and its producer/consumer.
// Carries the acc port only when ALU4_RESULT_ACC_EN is defined.
interface alu4_result_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic [7:0]    in_word;
  logic [2:0]    in_opcode;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_result;
  logic          out_carry;
  logic          out_zero;
  logic [2:0]    out_opcode;
  logic [CW-1:0] count;
  logic          fmt_err;
`ifdef ALU4_RESULT_ACC_EN
  logic [7:0]    acc;

  modport slave (
    input  flush, in_word, in_opcode, in_valid, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_opcode,
           count, fmt_err, acc
  );

  modport master (
    output flush, in_word, in_opcode, in_valid, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_opcode,
           count, fmt_err, acc
  );
`else
  modport slave (
    input  flush, in_word, in_opcode, in_valid, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_opcode,
           count, fmt_err
  );

  modport master (
    output flush, in_word, in_opcode, in_valid, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_opcode,
           count, fmt_err
  );
`endif
endinterface

// File: rtl/alu4_result_fifo.sv
// Capture FIFO for the 4-bit ALU: decodes result/carry/zero, tags with opcode,
// buffers DEPTH entries. Define ALU4_RESULT_ACC_EN to add the popped-value accumulator.
module alu4_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu4_result_fifo_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_SLOT  = AW'(DEPTH - 1);

  function automatic logic decode_zero(input logic [3:0] result);
    return (result == 4'h0);
  endfunction

  function automatic logic fmt_bad(input logic [7:0] word);
    return (word[3:1] != 3'b000);
  endfunction

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [7:0] acc_add(input logic [7:0] a, input logic c, input logic [3:0] r);
    return a + {3'b000, c, r};
  endfunction

  logic [3:0]    mem_result [DEPTH];
  logic          mem_carry  [DEPTH];
  logic          mem_zero   [DEPTH];
  logic [2:0]    mem_opcode [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] occ;
  logic          fmt_err_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Handshake qualifiers depend only on registered occupancy; flush masks both.
  assign full  = (occ == FULL_COUNT);
  assign empty = (occ == '0);
  assign push  = bus.in_valid && !full && !bus.flush;
  assign pop   = bus.out_ready && !empty && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      fmt_err_q <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      fmt_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (push && fmt_bad(bus.in_word)) begin
        fmt_err_q <= 1'b1;
      end
    end
  end

  // A cleared slot represents result 0, so its zero flag reads back as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= 4'h0;
        mem_carry[i]  <= 1'b0;
        mem_zero[i]   <= 1'b1;
        mem_opcode[i] <= 3'b000;
      end
    end else if (push) begin
      mem_result[wr_ptr] <= bus.in_word[7:4];
      mem_carry[wr_ptr]  <= bus.in_word[0];
      mem_zero[wr_ptr]   <= decode_zero(bus.in_word[7:4]);
      mem_opcode[wr_ptr] <= bus.in_opcode;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  assign bus.out_result = mem_result[rd_ptr];
  assign bus.out_carry  = mem_carry[rd_ptr];
  assign bus.out_zero   = mem_zero[rd_ptr];
  assign bus.out_opcode = mem_opcode[rd_ptr];
  assign bus.count      = occ;
  assign bus.fmt_err    = fmt_err_q;

`ifdef ALU4_RESULT_ACC_EN
  logic [7:0] acc_q;

  // Sum of popped {carry, result} values, wrapping at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 8'h00;
    end else if (bus.flush) begin
      acc_q <= 8'h00;
    end else if (pop) begin
      acc_q <= acc_add(acc_q, mem_carry[rd_ptr], mem_result[rd_ptr]);
    end
  end

  assign bus.acc = acc_q;
`endif

endmodule

// File: tb/tb_alu4_result_fifo.sv
// Randomised and directed bench for alu4_result_fifo against a queue-based model.
module tb_alu4_result_fifo;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu4_result_fifo_if #(.DEPTH(DEPTH)) bus ();
  alu4_result_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       z;
    logic [2:0] op;
  } ent_t;

  ent_t       q[$];
  logic       m_err = 1'b0;
  logic [7:0] m_acc = 8'h00;
  int         checks = 0;
  int         errors = 0;

  task automatic drive(input logic v, input logic [7:0] w, input logic [2:0] op,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_word   = w;
    bus.in_opcode = op;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  // Apply one clock edge to the model using the currently driven inputs, then to the DUT.
  task automatic tick();
    bit   do_push;
    bit   do_pop;
    int   sum;
    ent_t e;
    if (bus.flush) begin
      q.delete();
      m_err = 1'b0;
      m_acc = 8'h00;
    end else begin
      do_pop  = bus.out_ready && (q.size() > 0);
      do_push = bus.in_valid && (q.size() < DEPTH);
      e.r  = bus.in_word[7:4];
      e.c  = bus.in_word[0];
      e.z  = (bus.in_word[7:4] == 4'h0);
      e.op = bus.in_opcode;
      if (do_pop) begin
        sum   = int'(m_acc) + 16 * int'(q[0].c) + int'(q[0].r);
        m_acc = 8'(sum % 256);
        void'(q.pop_front());
      end
      if (do_push) begin
        q.push_back(e);
        if (bus.in_word[3:1] != 3'b000) m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fifo();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    clear_fifo();
    drive(1'b1, 8'h51, 3'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h1E, 3'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h70, 3'd3, 1'b0, 1'b0); tick();
    checks++;
    if (bus.count !== CW'(3) || bus.fmt_err !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre count=%0d fmt_err=%0b want 3/1", bus.count, bus.fmt_err);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.fmt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async count=%0d ov=%0b ir=%0b err=%0b want 0/0/1/0",
               bus.count, bus.out_valid, bus.in_ready, bus.fmt_err);
    end
    drive(1'b1, 8'h9E, 3'd7, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.fmt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_held count=%0d ov=%0b ir=%0b err=%0b want 0/0/1/0",
               bus.count, bus.out_valid, bus.in_ready, bus.fmt_err);
    end
    checks++;
    if ({bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode} !== {4'h0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_outs res=%h c=%b z=%b op=%0d want 0/0/1/0",
               bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode);
    end
    q.delete();
    m_err = 1'b0;
    m_acc = 8'h00;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.fmt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release count=%0d ov=%0b ir=%0b err=%0b want 0/0/1/0",
               bus.count, bus.out_valid, bus.in_ready, bus.fmt_err);
    end
  endtask

  task automatic test_basic();
    clear_fifo();
    drive(1'b1, 8'h51, 3'd0, 1'b0, 1'b0); tick();
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode} !== {4'h5, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL basic_first ov=%b res=%h c=%b z=%b op=%0d want 1/5/1/0/0",
               bus.out_valid, bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode);
    end
    drive(1'b1, 8'h00, 3'd2, 1'b0, 1'b0); tick();
    checks++;
    if (bus.count !== CW'(2) || bus.out_result !== 4'h5) begin
      errors++;
      $display("FAIL basic_two count=%0d res=%h want 2/5", bus.count, bus.out_result);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b1, 1'b0); tick();
    checks++;
    if ({bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode} !== {4'h0, 1'b0, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL basic_second res=%h c=%b z=%b op=%0d want 0/0/1/2",
               bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode);
    end
    tick();
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty count=%0d ov=%b want 0/0", bus.count, bus.out_valid);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_full_wrap();
    logic [3:0] exp_r [4];
    exp_r = '{4'hB, 4'hC, 4'hD, 4'hE};
    clear_fifo();
    drive(1'b1, 8'hA0, 3'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hB0, 3'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hC0, 3'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hD0, 3'd4, 1'b0, 1'b0); tick();
    checks++;
    if (bus.count !== CW'(4) || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_count count=%0d ir=%b want 4/0", bus.count, bus.in_ready);
    end
    drive(1'b1, 8'hE0, 3'd5, 1'b1, 1'b0); tick();
    checks++;
    if (bus.count !== CW'(3) || bus.out_result !== 4'hB) begin
      errors++;
      $display("FAIL full_reject count=%0d res=%h want 3/B", bus.count, bus.out_result);
    end
    drive(1'b1, 8'hE0, 3'd5, 1'b0, 1'b0); tick();
    checks++;
    if (bus.count !== CW'(4)) begin
      errors++;
      $display("FAIL full_refill count=%0d want 4", bus.count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp_r[i] || bus.out_opcode !== 3'(i + 2)) begin
        errors++;
        $display("FAIL wrap_order idx=%0d res=%h op=%0d want %h/%0d", i, bus.out_result,
                 bus.out_opcode, exp_r[i], i + 2);
      end
      drive(1'b0, 8'h00, 3'd0, 1'b1, 1'b0); tick();
    end
    checks++;
    if (bus.count !== '0) begin
      errors++;
      $display("FAIL wrap_empty count=%0d want 0", bus.count);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    clear_fifo();
    for (int i = 0; i < 2; i++) begin
      w = 8'($urandom) & 8'hF1;
      drive(1'b1, w, 3'($urandom), 1'b0, 1'b0); tick();
    end
    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom) & 8'hF1;
      drive(1'b1, w, 3'($urandom), 1'b1, 1'b0);
      checks++;
      if ({bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode} !== {q[0].r, q[0].c, q[0].z, q[0].op}) begin
        errors++;
        $display("FAIL b2b_head cyc=%0d got %h want %h", i,
                 {bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode}, q[0]);
      end
      tick();
      checks++;
      if (bus.count !== CW'(2)) begin
        errors++;
        $display("FAIL b2b_count cyc=%0d count=%0d want 2", i, bus.count);
      end
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_fmt_flush();
    clear_fifo();
    drive(1'b1, 8'h36, 3'd5, 1'b0, 1'b0); tick();
    checks++;
    if (bus.fmt_err !== 1'b1 || bus.count !== CW'(1) ||
        {bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode} !== {4'h3, 1'b0, 1'b0, 3'd5}) begin
      errors++;
      $display("FAIL fmt_store err=%b count=%0d res=%h c=%b z=%b op=%0d want 1/1/3/0/0/5",
               bus.fmt_err, bus.count, bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode);
    end
    drive(1'b1, 8'h51, 3'd1, 1'b1, 1'b1); tick();
    checks++;
    if (bus.count !== '0 || bus.fmt_err !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear count=%0d err=%b ov=%b want 0/0/0", bus.count, bus.fmt_err, bus.out_valid);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

`ifdef ALU4_RESULT_ACC_EN
  task automatic test_acc();
    logic [7:0] exp_acc [3];
    exp_acc = '{8'h1F, 8'h3E, 8'h40};
    clear_fifo();
    drive(1'b1, 8'hF1, 3'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hF1, 3'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h20, 3'd3, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 3'd0, 1'b1, 1'b0); tick();
      checks++;
      if (bus.acc !== exp_acc[i]) begin
        errors++;
        $display("FAIL acc_sum idx=%0d acc=%h want %h", i, bus.acc, exp_acc[i]);
      end
    end
    clear_fifo();
    checks++;
    if (bus.acc !== 8'h00) begin
      errors++;
      $display("FAIL acc_flush acc=%h want 00", bus.acc);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] w;
    logic       v;
    logic       rdy;
    logic       fl;
    clear_fifo();
    for (int i = 0; i < 400; i++) begin
      w = 8'($urandom);
      if ($urandom_range(0, 7) != 0) w[3:1] = 3'b000;
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 29) == 0);
      drive(v, w, 3'($urandom), rdy, fl);
      tick();
      checks++;
      if (bus.count !== CW'(q.size()) || bus.in_ready !== (q.size() < DEPTH) ||
          bus.out_valid !== (q.size() > 0) || bus.fmt_err !== m_err) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d count=%0d ir=%b ov=%b err=%b want %0d/%b/%b/%b", i,
                 bus.count, bus.in_ready, bus.out_valid, bus.fmt_err,
                 q.size(), q.size() < DEPTH, q.size() > 0, m_err);
      end
      if (q.size() > 0) begin
        checks++;
        if ({bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode} !== {q[0].r, q[0].c, q[0].z, q[0].op}) begin
          errors++;
          $display("FAIL rand_head cyc=%0d got %h want %h", i,
                   {bus.out_result, bus.out_carry, bus.out_zero, bus.out_opcode}, q[0]);
        end
      end
`ifdef ALU4_RESULT_ACC_EN
      checks++;
      if (bus.acc !== m_acc) begin
        errors++;
        $display("FAIL rand_acc cyc=%0d acc=%h want %h", i, bus.acc, m_acc);
      end
`endif
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_back_to_back();
    test_fmt_flush();
`ifdef ALU4_RESULT_ACC_EN
    test_acc();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu4_result_fifo.md
# alu4_result_fifo

Downstream capture stage for the 4-bit ALU. It samples the ALU's packed output byte together with the opcode that produced it, and decodes result, carry and zero flags. It buffers up to DEPTH tagged results in a FIFO and hands them to a consumer over a valid/ready handshake. This lets the operand source issue back-to-back operations without waiting for the reader.

## Interface

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; the only reset in the block.
- flush  input  1  synchronous clear of the FIFO contents and of fmt_err.
- in_word  input  8  ALU output byte: [7:4]=result, [3:1]=must be 000, [0]=carry-out.
- in_opcode  input  3  opcode that produced in_word; stored as a tag.
- in_valid  input  1  producer offers in_word/in_opcode.
- in_ready  output  1  FIFO can accept; equals !full.
- out_valid  output  1  head entry present; equals !empty.
- out_ready  input  1  consumer takes head entry.
- out_result  output  4  head result nibble.
- out_carry  output  1  head carry flag.
- out_zero  output  1  head zero flag.
- out_opcode  output  3  head opcode tag.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- fmt_err  output  1  sticky flag: an accepted word had nonzero bits [3:1].

## Operation

- Push occurs when in_valid && in_ready. The stored entry is:
  - result = in_word[7:4]
  - carry = in_word[0]
  - zero = (in_word[7:4] == 4'h0)
  - opcode = in_opcode
- Zero is computed on the 4-bit result only; carry does not affect it.
- Pop occurs when out_valid && out_ready. The read pointer advances to the next entry.
- Storage is a circular buffer with separate read and write pointers of clog2(DEPTH) bits; both wrap from DEPTH-1 to 0.
- Occupancy is tracked by count. Full is count==DEPTH; empty is count==0.
- Simultaneous push and pop:
  - When neither full nor empty, both occur and count is unchanged.
  - When full, in_ready is low, so only the pop occurs. Push is not accepted even though a slot frees that cycle.
  - When empty, out_valid is low, so only the push occurs. There is no fall-through.
- out_ready while empty and in_valid while full are ignored; no state change.
- fmt_err sets on any accepted push with in_word[3:1] != 3'b000. The entry is still stored normally. fmt_err stays set until flush or rst.
- flush: pointers and count go to 0 and fmt_err clears. Flush dominates any push or pop in the same cycle; neither takes effect.
- Output fields present the head entry combinationally from storage. When empty they are don't-care, and the bench must not check them.

## Timing

- Reset values:
  - count=0, in_ready=1, out_valid=0, fmt_err=0
  - out_result=0, out_carry=0, out_zero=1, out_opcode=0
  - Storage is cleared to 0.
- Reset mid-operation discards all entries immediately (asynchronous). Inputs are ignored while rst is high.
- Latency: a word pushed at edge N is visible on the out_* ports with out_valid=1 after edge N (1 cycle) if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- in_ready and out_valid depend only on registered count; there is no combinational path from in_valid or out_ready.
- fmt_err asserts in the cycle after the offending push edge.

## Configuration

- Macro ALU4_RESULT_ACC_EN.
- Defined:
  - Adds output acc (8 bits): a running sum of every popped entry's {3'b000, carry, result} as an unsigned 5-bit value.
  - The sum wraps modulo 256.
  - acc updates on the pop edge and is cleared by rst and by flush.
- Undefined: the acc port and accumulator logic are absent; all other behaviour is identical.

## Test plan

- Reset/idle: assert rst mid-stream with 3 entries held. Required: count=0, out_valid=0, in_ready=1, fmt_err=0 while rst is high and after release.
- Basic push/pop: push in_word=8'h51 with opcode 0, then 8'h00 with opcode 2, then pop both. Required heads, in order:
  - result=5, carry=1, zero=0, op=0
  - result=0, carry=0, zero=1, op=2
- Full and wrap, DEPTH=4:
  - Push 4 words A0,B0,C0,D0 → count=4, in_ready=0.
  - Offer E0 with in_valid and out_ready both high → A0 pops and E0 is rejected; count=3.
  - Push E0, then pop all → order is B0,C0,D0,E0, with the pointers having wrapped.
- Simultaneous push/pop at count=2: hold in_valid and out_ready high for 10 cycles. Required: count stays 2 and output order equals input order.
- Format error and flush: push 8'h36. Required: stored with result=3, carry=0; fmt_err=1 on the next cycle. Then pulse flush together with in_valid → count=0, fmt_err=0, and nothing pushed.
- With ALU4_RESULT_ACC_EN defined: push and pop 8'hF1, 8'hF1, 8'h20. Required: acc=0x1F, then 0x3E, then 0x40. A flush returns acc to 0.
